gte_ctrl: RTL and testbench
===========================

# gte_ctrl

Sequencer between the MIPS pipeline's COP2 decode and the `gte` coprocessor. It accepts one COP2 operation at a time over a valid/ack handshake and drives the GTE's one-cycle transfer strobes and command fields. It tracks command execution with a per-opcode cycle counter and interlocks further COP2 traffic while a command runs. Register reads complete on `gte_out_avail`, with a timeout.

## Interface
Parameters:
- `DEFAULT_LAT`, 8: busy cycles for a command opcode absent from the latency table.
- `RD_TIMEOUT`, 16: cycles spent in RD_WAIT before a read is forced to complete.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cpu_valid` in 1: COP2 op presented. The CPU holds the op and all fields stable until `cpu_ack`.
- `cpu_op` in 3: `cop2_op_t` (CMD, MFC2, CFC2, MTC2, CTC2, LWC2, SWC2).
- `cpu_imm` in 25: imm25 field of the COP2 command instruction.
- `cpu_rd` in 5: GTE register index.
- `cpu_wdata` in 32: GPR value for MTC2/CTC2, or memory data for LWC2.
- `cpu_ack` out 1: op complete this cycle.
- `cpu_stall` out 1: `cpu_valid & ~cpu_ack`.
- `cpu_rdata` out 32: read result, valid when `cpu_ack` is high for a read op.
- `rd_err` out 1: sticky read-timeout flag, cleared only by `rst`.
- `gte_mfc2`, `gte_cfc2`, `gte_mtc2`, `gte_ctc2`, `gte_lwc2`, `gte_swc2` out 1 each: one-cycle transfer strobes.
- `gte_rd` out 5; `gte_reg_in` out 32; `gte_reg_in_rdy` out 1.
- `gte_inst_rdy` out 1; `gte_sf` out 1; `gte_mx`, `gte_vx`, `gte_tx` out 2 each; `gte_lm` out 1; `gte_cmd` out 6.
- `gte_reg_out` in 32; `gte_out_avail` in 1.
- `gte_busy` out 1: high while the controller is in state BUSY.

## Operation
- FSM states: IDLE, BUSY, RD_WAIT, RD_DONE.
- All GTE-side outputs are registered.
- `cpu_ack` is combinational:
  - In IDLE: high for CMD and write ops.
  - In RD_DONE: high.
  - Otherwise: low.
- **Write ops** (MTC2, CTC2, LWC2), accepted in IDLE at cycle T:
  - `cpu_ack` is high at T.
  - At T+1: the matching strobe and `gte_reg_in_rdy` are high; `gte_rd = cpu_rd`; `gte_reg_in = cpu_wdata`.
  - State stays IDLE, so back-to-back writes run at 1 per cycle.
- **CMD**, accepted in IDLE at cycle T:
  - `cpu_ack` is high at T.
  - At T+1: `gte_inst_rdy` is high and the fields are decoded from `cpu_imm`: `sf = imm[19]`, `mx = imm[18:17]`, `vx = imm[16:15]`, `tx = imm[14:13]`, `lm = imm[10]`, `cmd = imm[5:0]`.
  - The state enters BUSY at T+1, with the counter loaded to LAT−1.
  - The counter decrements each cycle. When the counter is 0 the FSM returns to IDLE, so BUSY lasts exactly LAT cycles (T+1 through T+LAT).
- **Read ops** (MFC2, CFC2, SWC2), accepted in IDLE at cycle T:
  - No ack at T.
  - At T+1: the matching strobe is high, `gte_rd = cpu_rd`, and the state enters RD_WAIT with the timeout counter at 0.
  - In RD_WAIT, when `gte_out_avail` is high: `cpu_rdata <= gte_reg_out` and the state moves to RD_DONE.
  - In RD_DONE: `cpu_ack` is high for exactly one cycle, then the state returns to IDLE.
  - Timeout: when the counter reaches RD_TIMEOUT−1 without `gte_out_avail`, `cpu_rdata <= 0`, `rd_err <= 1`, and the state moves to RD_DONE.
- Any op presented in BUSY, RD_WAIT or RD_DONE is not acknowledged and is held; the lone exception is the read being completed in RD_DONE.
- An invalid `cpu_op` encoding is acked in IDLE with no strobe.

## Timing
- Reset values: state IDLE, both counters 0, `rd_err` 0, `cpu_rdata` 0, and every strobe, `gte_inst_rdy`, `gte_reg_in_rdy` and `gte_busy` 0. All field outputs are also 0.
- `rst` asserted mid-operation aborts any BUSY or read in progress, with no ack. The first op after `rst` deasserts is accepted immediately.
- Op costs:
  - Write: 1 cycle.
  - CMD: 1 cycle, plus LAT busy cycles blocking the next op.
  - Read: minimum 3 cycles (out_avail at T+1, ack at T+2). The worst case is RD_TIMEOUT+2 cycles.
- An op accepted on the cycle BUSY's counter hits 0 is not possible, because the state is not yet IDLE. The next op is acked at T+LAT+1 at the earliest.
- Strobes are never high for more than one cycle per op.

## Structure
- `gte_pkg`:
  - `cop2_op_t` enum.
  - The `gte_cmd` opcode localparams.
  - Function `gte_cmd_lat(cmd)` implementing this table: RTPS 15, NCLIP 8, OP 6, DPCS 8, INTPL 8, MVMVA 8, NCDS 19, CDP 13, NCDT 44, NCCS 17, CC 11, NCS 14, NCT 30, SQR 5, DCPL 8, DPCT 17, AVSZ3 5, AVSZ4 6, RTPT 23, GPF 5, GPL 5, NCCT 39. Any other opcode returns DEFAULT_LAT.
  - FSM state enum.
- No sub-module; the design is a single FSM plus two counters.

## Test plan
- Reset: hold `rst` for 2 cycles → every output 0, then a CMD is acked on the first cycle after deassertion.
- MTC2 with `rd=5`, `wdata=0x1234_5678` → ack at T; at T+1, `gte_mtc2=1`, `gte_rd=5`, `gte_reg_in=0x1234_5678`, `gte_reg_in_rdy=1`, each for one cycle only.
- CMD with `imm=0x0080001` (RTPS, sf=1) → at T+1, `gte_inst_rdy=1`, `gte_sf=1`, `gte_cmd=0x01`; `gte_busy` is high for 15 cycles; an MFC2 presented at T+1 is stalled until acceptance at T+16.
- MFC2 with `rd=7`, `gte_out_avail` high at T+3 with `gte_reg_out=0xDEAD_BEEF` → ack at T+4 with `cpu_rdata=0xDEAD_BEEF`; `rd_err` stays 0.
- CFC2 with `gte_out_avail` never asserted → ack at T+17 with `cpu_rdata=0`; `rd_err` becomes 1 and stays 1 through later ops.
- `rst` pulsed at cycle 5 of a NCDT (44-cycle) command → `gte_busy` is 0 the next cycle, and an MTC2 is acked immediately.

Source files
------------

// File: rtl/gte_pkg.sv
// Shared types for the COP2/GTE sequencer: op encoding, FSM states, GTE opcodes and their latencies.
package gte_pkg;

    typedef enum logic [2:0] {
        COP2_CMD  = 3'd0,
        COP2_MFC2 = 3'd1,
        COP2_CFC2 = 3'd2,
        COP2_MTC2 = 3'd3,
        COP2_CTC2 = 3'd4,
        COP2_LWC2 = 3'd5,
        COP2_SWC2 = 3'd6
    } cop2_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_DONE = 2'd3
    } gte_state_t;

    localparam logic [5:0] CMD_RTPS  = 6'h01;
    localparam logic [5:0] CMD_NCLIP = 6'h06;
    localparam logic [5:0] CMD_OP    = 6'h0C;
    localparam logic [5:0] CMD_DPCS  = 6'h10;
    localparam logic [5:0] CMD_INTPL = 6'h11;
    localparam logic [5:0] CMD_MVMVA = 6'h12;
    localparam logic [5:0] CMD_NCDS  = 6'h13;
    localparam logic [5:0] CMD_CDP   = 6'h14;
    localparam logic [5:0] CMD_NCDT  = 6'h16;
    localparam logic [5:0] CMD_NCCS  = 6'h1B;
    localparam logic [5:0] CMD_CC    = 6'h1C;
    localparam logic [5:0] CMD_NCS   = 6'h1E;
    localparam logic [5:0] CMD_NCT   = 6'h20;
    localparam logic [5:0] CMD_SQR   = 6'h28;
    localparam logic [5:0] CMD_DCPL  = 6'h29;
    localparam logic [5:0] CMD_DPCT  = 6'h2A;
    localparam logic [5:0] CMD_AVSZ3 = 6'h2D;
    localparam logic [5:0] CMD_AVSZ4 = 6'h2E;
    localparam logic [5:0] CMD_RTPT  = 6'h30;
    localparam logic [5:0] CMD_GPF   = 6'h3D;
    localparam logic [5:0] CMD_GPL   = 6'h3E;
    localparam logic [5:0] CMD_NCCT  = 6'h3F;

    // Execution cycles per command opcode; unknown opcodes fall back to default_lat.
    function automatic logic [7:0] gte_cmd_lat(input logic [5:0] cmd, input logic [7:0] default_lat);
        logic [7:0] lat;
        case (cmd)
            CMD_RTPS:  lat = 8'd15;
            CMD_NCLIP: lat = 8'd8;
            CMD_OP:    lat = 8'd6;
            CMD_DPCS:  lat = 8'd8;
            CMD_INTPL: lat = 8'd8;
            CMD_MVMVA: lat = 8'd8;
            CMD_NCDS:  lat = 8'd19;
            CMD_CDP:   lat = 8'd13;
            CMD_NCDT:  lat = 8'd44;
            CMD_NCCS:  lat = 8'd17;
            CMD_CC:    lat = 8'd11;
            CMD_NCS:   lat = 8'd14;
            CMD_NCT:   lat = 8'd30;
            CMD_SQR:   lat = 8'd5;
            CMD_DCPL:  lat = 8'd8;
            CMD_DPCT:  lat = 8'd17;
            CMD_AVSZ3: lat = 8'd5;
            CMD_AVSZ4: lat = 8'd6;
            CMD_RTPT:  lat = 8'd23;
            CMD_GPF:   lat = 8'd5;
            CMD_GPL:   lat = 8'd5;
            CMD_NCCT:  lat = 8'd39;
            default:   lat = default_lat;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/gte_ctrl.sv
// COP2 sequencer: accepts one op at a time from the CPU, strobes the GTE, and interlocks
// further traffic while a command executes or a register read is outstanding.
module gte_ctrl
    import gte_pkg::*;
#(
    parameter int DEFAULT_LAT = 8,
    parameter int RD_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    input  logic [2:0]  cpu_op,
    input  logic [24:0] cpu_imm,
    input  logic [4:0]  cpu_rd,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        rd_err,
    output logic        gte_mfc2,
    output logic        gte_cfc2,
    output logic        gte_mtc2,
    output logic        gte_ctc2,
    output logic        gte_lwc2,
    output logic        gte_swc2,
    output logic [4:0]  gte_rd,
    output logic [31:0] gte_reg_in,
    output logic        gte_reg_in_rdy,
    output logic        gte_inst_rdy,
    output logic        gte_sf,
    output logic [1:0]  gte_mx,
    output logic [1:0]  gte_vx,
    output logic [1:0]  gte_tx,
    output logic        gte_lm,
    output logic [5:0]  gte_cmd,
    input  logic [31:0] gte_reg_out,
    input  logic        gte_out_avail,
    output logic        gte_busy,
    output gte_state_t  fsm_state
);

    localparam logic [15:0] RD_LAST = 16'(RD_TIMEOUT - 1);

    gte_state_t  state, state_n;
    logic [7:0]  busy_cnt;
    logic [15:0] rd_cnt;
    logic        is_cmd, is_wr, is_rd;
    logic        acc_cmd, acc_wr, acc_rd;
    logic        rd_timeout;
    logic [7:0]  cmd_lat;

    // Handshake: the CPU raises cpu_valid and holds op/fields until cpu_ack; cpu_ack
    // is the only completion signal, reads ack in RD_DONE, everything else acks in IDLE.
    assign is_cmd = (cpu_op == COP2_CMD);
    assign is_wr  = (cpu_op == COP2_MTC2) || (cpu_op == COP2_CTC2) || (cpu_op == COP2_LWC2);
    assign is_rd  = (cpu_op == COP2_MFC2) || (cpu_op == COP2_CFC2) || (cpu_op == COP2_SWC2);
    assign rd_timeout = (rd_cnt == RD_LAST);
    assign cmd_lat = gte_cmd_lat(cpu_imm[5:0], 8'(DEFAULT_LAT));
    assign cpu_stall = cpu_valid & ~cpu_ack;
    assign fsm_state = state;

    // imm25 bits outside the decoded command fields are don't-care here.
    logic unused_imm;
    assign unused_imm = ^{cpu_imm[24:20], cpu_imm[12:11], cpu_imm[9:6]};

    always_comb begin
        state_n = state;
        cpu_ack = 1'b0;
        acc_cmd = 1'b0;
        acc_wr  = 1'b0;
        acc_rd  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_valid) begin
                    if (is_rd) begin
                        acc_rd  = 1'b1;
                        state_n = ST_RD_WAIT;
                    end else begin
                        cpu_ack = 1'b1;
                        acc_cmd = is_cmd;
                        acc_wr  = is_wr;
                        if (is_cmd) state_n = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (busy_cnt == 8'd0) state_n = ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (gte_out_avail || rd_timeout) state_n = ST_RD_DONE;
            end
            ST_RD_DONE: begin
                cpu_ack = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            busy_cnt       <= '0;
            rd_cnt         <= '0;
            rd_err         <= 1'b0;
            cpu_rdata      <= '0;
            gte_mfc2       <= 1'b0;
            gte_cfc2       <= 1'b0;
            gte_mtc2       <= 1'b0;
            gte_ctc2       <= 1'b0;
            gte_lwc2       <= 1'b0;
            gte_swc2       <= 1'b0;
            gte_rd         <= '0;
            gte_reg_in     <= '0;
            gte_reg_in_rdy <= 1'b0;
            gte_inst_rdy   <= 1'b0;
            gte_sf         <= 1'b0;
            gte_mx         <= '0;
            gte_vx         <= '0;
            gte_tx         <= '0;
            gte_lm         <= 1'b0;
            gte_cmd        <= '0;
            gte_busy       <= 1'b0;
        end else begin
            state          <= state_n;
            gte_busy       <= (state_n == ST_BUSY);
            gte_mfc2       <= acc_rd && (cpu_op == COP2_MFC2);
            gte_cfc2       <= acc_rd && (cpu_op == COP2_CFC2);
            gte_swc2       <= acc_rd && (cpu_op == COP2_SWC2);
            gte_mtc2       <= acc_wr && (cpu_op == COP2_MTC2);
            gte_ctc2       <= acc_wr && (cpu_op == COP2_CTC2);
            gte_lwc2       <= acc_wr && (cpu_op == COP2_LWC2);
            gte_reg_in_rdy <= acc_wr;
            gte_inst_rdy   <= acc_cmd;

            if (acc_wr || acc_rd) gte_rd <= cpu_rd;
            if (acc_wr) gte_reg_in <= cpu_wdata;

            if (acc_cmd) begin
                gte_sf   <= cpu_imm[19];
                gte_mx   <= cpu_imm[18:17];
                gte_vx   <= cpu_imm[16:15];
                gte_tx   <= cpu_imm[14:13];
                gte_lm   <= cpu_imm[10];
                gte_cmd  <= cpu_imm[5:0];
                busy_cnt <= cmd_lat - 8'd1;
            end else if (state == ST_BUSY && busy_cnt != 8'd0) begin
                busy_cnt <= busy_cnt - 8'd1;
            end

            if (acc_rd) begin
                rd_cnt <= '0;
            end else if (state == ST_RD_WAIT && state_n == ST_RD_WAIT) begin
                rd_cnt <= rd_cnt + 16'd1;
            end

            // Data arriving on the last timeout cycle still wins over the timeout.
            if (state == ST_RD_WAIT) begin
                if (gte_out_avail) begin
                    cpu_rdata <= gte_reg_out;
                end else if (rd_timeout) begin
                    cpu_rdata <= '0;
                    rd_err    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gte_ctrl.sv
// Directed plus randomized bench for gte_ctrl, checked against an op-level timing/data model.
module tb_gte_ctrl;
    import gte_pkg::*;

    localparam int DEF_LAT = 8;
    localparam int RD_TO   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid;
    logic [2:0]  cpu_op;
    logic [24:0] cpu_imm;
    logic [4:0]  cpu_rd;
    logic [31:0] cpu_wdata;
    logic        cpu_ack, cpu_stall, rd_err;
    logic [31:0] cpu_rdata;
    logic        gte_mfc2, gte_cfc2, gte_mtc2, gte_ctc2, gte_lwc2, gte_swc2;
    logic [4:0]  gte_rd;
    logic [31:0] gte_reg_in;
    logic        gte_reg_in_rdy, gte_inst_rdy, gte_sf, gte_lm, gte_busy;
    logic [1:0]  gte_mx, gte_vx, gte_tx;
    logic [5:0]  gte_cmd;
    logic [31:0] gte_reg_out;
    logic        gte_out_avail;
    gte_state_t  fsm_state;

    int checks = 0;
    int errors = 0;
    logic err_exp = 1'b0;

    gte_ctrl #(.DEFAULT_LAT(DEF_LAT), .RD_TIMEOUT(RD_TO)) dut (
        .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_op(cpu_op), .cpu_imm(cpu_imm),
        .cpu_rd(cpu_rd), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata), .rd_err(rd_err),
        .gte_mfc2(gte_mfc2), .gte_cfc2(gte_cfc2), .gte_mtc2(gte_mtc2), .gte_ctc2(gte_ctc2),
        .gte_lwc2(gte_lwc2), .gte_swc2(gte_swc2), .gte_rd(gte_rd), .gte_reg_in(gte_reg_in),
        .gte_reg_in_rdy(gte_reg_in_rdy), .gte_inst_rdy(gte_inst_rdy), .gte_sf(gte_sf),
        .gte_mx(gte_mx), .gte_vx(gte_vx), .gte_tx(gte_tx), .gte_lm(gte_lm), .gte_cmd(gte_cmd),
        .gte_reg_out(gte_reg_out), .gte_out_avail(gte_out_avail), .gte_busy(gte_busy),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    wire [5:0] strobes = {gte_mfc2, gte_cfc2, gte_mtc2, gte_ctc2, gte_lwc2, gte_swc2};

    function automatic logic [5:0] exp_strobes(input logic [2:0] op);
        case (op)
            3'd1:    return 6'b100000;
            3'd2:    return 6'b010000;
            3'd3:    return 6'b001000;
            3'd4:    return 6'b000100;
            3'd5:    return 6'b000010;
            3'd6:    return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic int ref_lat(input int opc);
        case (opc)
            'h01: return 15;  'h06: return 8;   'h0C: return 6;   'h10: return 8;
            'h11: return 8;   'h12: return 8;   'h13: return 19;  'h14: return 13;
            'h16: return 44;  'h1B: return 17;  'h1C: return 11;  'h1E: return 14;
            'h20: return 30;  'h28: return 5;   'h29: return 8;   'h2A: return 17;
            'h2D: return 5;   'h2E: return 6;   'h30: return 23;  'h3D: return 5;
            'h3E: return 5;   'h3F: return 39;
            default: return DEF_LAT;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    // Write or invalid op: acked at T, strobes/data at T+1 only.
    task automatic do_write(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] wd);
        bit real_wr = (op >= 3'd3 && op <= 3'd5);
        cpu_valid = 1'b1; cpu_op = op; cpu_rd = rd; cpu_wdata = wd;
        @(negedge clk);
        chk("wr_ack", cpu_ack, 1'b1);
        chk("wr_stall", cpu_stall, 1'b0);
        next_drive();
        cpu_valid = 1'b0; cpu_rd = 5'($urandom); cpu_wdata = $urandom;
        @(negedge clk);
        chk("wr_strobe", strobes, exp_strobes(op));
        chk("wr_rdy", gte_reg_in_rdy, real_wr);
        if (real_wr) begin
            chk("wr_rd", gte_rd, rd);
            chk("wr_data", gte_reg_in, wd);
        end
        next_drive();
        @(negedge clk);
        chk("wr_strobe_off", {strobes, gte_reg_in_rdy}, 7'd0);
        next_drive();
    endtask

    // Command: fields at T+1, busy for the table latency; optionally an MFC2 waits behind it.
    task automatic do_cmd(input logic [24:0] imm, input bit stall_read);
        int lat = ref_lat(int'(imm & 25'h3F));
        int n = 0;
        bit acked = 1'b0;
        cpu_valid = 1'b1; cpu_op = COP2_CMD; cpu_imm = imm;
        @(negedge clk);
        chk("cmd_ack", cpu_ack, 1'b1);
        next_drive();
        if (stall_read) begin
            cpu_op = COP2_MFC2; cpu_rd = 5'd7;
        end else begin
            cpu_valid = 1'b0;
        end
        cpu_imm = 25'($urandom);
        @(negedge clk);
        chk("cmd_inst_rdy", gte_inst_rdy, 1'b1);
        chk("cmd_sf", gte_sf, (imm >> 19) & 1);
        chk("cmd_mx", gte_mx, (imm >> 17) & 3);
        chk("cmd_vx", gte_vx, (imm >> 15) & 3);
        chk("cmd_tx", gte_tx, (imm >> 13) & 3);
        chk("cmd_lm", gte_lm, (imm >> 10) & 1);
        chk("cmd_op", gte_cmd, imm & 25'h3F);
        for (int i = 0; i < 100; i++) begin
            if (!gte_busy) break;
            n++;
            if (cpu_ack) acked = 1'b1;
            if (i == 1) chk("cmd_inst_rdy_off", gte_inst_rdy, 1'b0);
            next_drive();
            @(negedge clk);
        end
        chk("cmd_busy_len", n, lat);
        if (stall_read) begin
            chk("stall_no_ack", {acked, cpu_ack}, 2'b00);
            next_drive();
            gte_out_avail = 1'b1; gte_reg_out = 32'hCAFE_F00D;
            @(negedge clk);
            chk("stall_mfc2", strobes, 6'b100000);
            chk("stall_rd", gte_rd, 5'd7);
            next_drive();
            gte_out_avail = 1'b0; gte_reg_out = $urandom;
            @(negedge clk);
            chk("stall_rd_ack", cpu_ack, 1'b1);
            chk("stall_rdata", cpu_rdata, 32'hCAFE_F00D);
        end
        next_drive();
        cpu_valid = 1'b0;
    endtask

    // Read: out_avail pulsed k cycles after presentation (k=0 means never).
    task automatic do_read(input logic [2:0] op, input logic [4:0] rd, input int k, input logic [31:0] data);
        bit timed_out = !(k >= 1 && k <= RD_TO);
        int exp_off = timed_out ? RD_TO + 1 : k + 1;
        int got = -1;
        err_exp = err_exp | timed_out;
        cpu_valid = 1'b1; cpu_op = op; cpu_rd = rd; gte_out_avail = 1'b0; gte_reg_out = $urandom;
        @(negedge clk);
        chk("rd_ack_at_T", cpu_ack, 1'b0);
        for (int c = 1; c < 40; c++) begin
            next_drive();
            gte_out_avail = (c == k);
            gte_reg_out = (c == k) ? data : $urandom;
            @(negedge clk);
            if (c == 1) begin
                chk("rd_strobe", strobes, exp_strobes(op));
                chk("rd_rd", gte_rd, rd);
            end
            if (c == 2) chk("rd_strobe_off", strobes, 6'd0);
            if (cpu_ack) begin
                got = c;
                break;
            end
        end
        chk("rd_latency", got, exp_off);
        chk("rd_data", cpu_rdata, timed_out ? 32'd0 : data);
        chk("rd_err", rd_err, err_exp);
        next_drive();
        cpu_valid = 1'b0; gte_out_avail = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cpu_valid = 1'b0; cpu_op = '0; cpu_imm = '0; cpu_rd = '0; cpu_wdata = '0;
        gte_reg_out = '0; gte_out_avail = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu", {cpu_ack, cpu_stall, rd_err, cpu_rdata}, 64'd0);
        chk("rst_strobes", {strobes, gte_reg_in_rdy, gte_inst_rdy, gte_busy}, 64'd0);
        chk("rst_data", {gte_rd, gte_reg_in}, 64'd0);
        chk("rst_fields", {gte_sf, gte_mx, gte_vx, gte_tx, gte_lm, gte_cmd}, 64'd0);
        chk("rst_state", fsm_state, ST_IDLE);
        next_drive();
        rst = 1'b0;
        do_cmd(25'h000000C | (25'($urandom) & 25'h1FFFFC0), 1'b0);

        do_write(COP2_MTC2, 5'd5, 32'h1234_5678);
        do_cmd(25'h0080001, 1'b1);
        do_read(COP2_MFC2, 5'd7, 3, 32'hDEAD_BEEF);
        do_write(3'd7, 5'd3, 32'h5555_AAAA);
        do_read(COP2_SWC2, 5'd1, 1, 32'h0BAD_F00D);
        do_read(COP2_CFC2, 5'd9, RD_TO, 32'h7777_0001);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: do_write(3'($urandom_range(3, 5)), 5'($urandom), $urandom);
                1: do_cmd(25'($urandom), 1'b0);
                default: begin
                    int kk = $urandom_range(0, 6) == 0 ? 0 : $urandom_range(1, RD_TO + 3);
                    logic [2:0] rop;
                    case ($urandom_range(0, 2))
                        0: rop = COP2_MFC2;
                        1: rop = COP2_CFC2;
                        default: rop = COP2_SWC2;
                    endcase
                    do_read(rop, 5'($urandom), kk, $urandom);
                end
            endcase
        end

        do_read(COP2_CFC2, 5'd2, 0, 32'hFFFF_FFFF);
        do_write(COP2_CTC2, 5'd4, $urandom);
        do_cmd(25'h0000028, 1'b0);
        chk("rd_err_sticky", rd_err, 1'b1);

        // Reset in the middle of a long NCDT.
        cpu_valid = 1'b1; cpu_op = COP2_CMD; cpu_imm = 25'h0000016;
        @(negedge clk);
        chk("ncdt_ack", cpu_ack, 1'b1);
        next_drive();
        cpu_valid = 1'b0;
        repeat (4) next_drive();
        rst = 1'b1;
        @(negedge clk);
        chk("ncdt_busy_before_rst", gte_busy, 1'b1);
        next_drive();
        rst = 1'b0; err_exp = 1'b0;
        cpu_valid = 1'b1; cpu_op = COP2_MTC2; cpu_rd = 5'd11; cpu_wdata = 32'hA5A5_0F0F;
        @(negedge clk);
        chk("post_rst_busy", gte_busy, 1'b0);
        chk("post_rst_ack", cpu_ack, 1'b1);
        chk("post_rst_err", rd_err, 1'b0);
        next_drive();
        cpu_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_mtc2", strobes, 6'b001000);
        chk("post_rst_data", gte_reg_in, 32'hA5A5_0F0F);
        next_drive();
        do_read(COP2_MFC2, 5'd6, 2, 32'h0101_2020);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

endmodule
